usr_seq: RTL
============

Name: usr_seq

Overview:
- Sequencer that drives a WIDTH-bit universal shift register (USR) through complete commands.
- Commands: parallel-to-serial transmit, serial-to-parallel receive, rotate-left and rotate-right by N.
- Accepts one command at a time over a valid/ready handshake and generates the USR select, serial-in and parallel-in controls.
- Returns the final register contents over a valid/ready response channel. Sits between command logic and the usr instance.

Parameters:
- WIDTH, 4, USR width in bits.
- AMT_W, 3, width of the rotate amount field.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when valid and ready are both high.
- cmd_op  input  2  00 TX, 01 RX, 10 ROTL, 11 ROTR.
- cmd_data  input  WIDTH  load value for TX/ROTL/ROTR; ignored for RX.
- cmd_amt  input  AMT_W  rotate count; ignored for TX/RX.
- ser_out  output  1  TX bit, LSB first.
- ser_valid  output  1  ser_out is meaningful this cycle.
- ser_in  input  1  RX bit.
- ser_ready  output  1  ser_in is sampled this cycle.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed.
- rsp_data  output  WIDTH  USR contents at completion.
- busy  output  1  high in any state other than IDLE.
- usr_select  output  2  00 hold, 01 shift-down, 10 shift-up, 11 parallel load.
  - Shift-down: q[k] takes q[k+1]; q[WIDTH-1] takes s_right.
  - Shift-up: q[k] takes q[k-1]; q[0] takes s_left.
- usr_s_left  output  1  serial input at q[0] for shift-up.
- usr_s_right  output  1  serial input at q[WIDTH-1] for shift-down.
- usr_i  output  WIDTH  parallel load value.
- usr_q  input  WIDTH  current USR contents.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- FSM states: IDLE, LOAD, SHIFT, RESP. State, opcode, data and count are registered. All outputs decode combinationally from registered state and usr_q.
- Reset values:
  - State IDLE.
  - cmd_ready=0 while rst is high; cmd_ready=1 on the first cycle after rst falls.
  - rsp_valid=0, ser_valid=0, ser_ready=0, busy=0.
  - usr_select=00, usr_i=0, usr_s_left=0, usr_s_right=0, rsp_data=0.
- IDLE:
  - cmd_ready=1 and usr_select=00.
  - On handshake (cycle 0), capture op/data/amt, set count to WIDTH (TX/RX) or amt (ROT), and go to LOAD.
- LOAD (cycle 1):
  - usr_select=11.
  - usr_i = cmd_data, or 0 for RX.
  - Go to SHIFT if count≠0, else to RESP.
- SHIFT (one cycle per count, decrement each cycle, go to RESP when count reaches 1):
  - TX: select=01, s_right=0, ser_out=usr_q[0], ser_valid=1.
  - RX: select=10, s_left=ser_in, ser_ready=1. The first received bit ends in q[WIDTH-1].
  - ROTL: select=10, s_left=usr_q[WIDTH-1].
  - ROTR: select=01, s_right=usr_q[0].
- Latency: TX/RX give rsp_valid at cycle WIDTH+2; ROT gives rsp_valid at cycle amt+2.
- amt ≥ WIDTH is performed literally, with no modulo reduction.
- RESP:
  - usr_select=00; rsp_valid=1; rsp_data=usr_q.
  - Hold until rsp_ready, then go to IDLE.
  - cmd_ready=0 in RESP, so cmd_valid is ignored. Next command is accepted no earlier than one cycle after the response handshake.
  - rsp_data stays stable while stalled.
- Reset mid-operation: FSM is in IDLE at the next edge. usr_select=00 during reset. The controller does not clear USR contents. Pending serial bits are lost and no response is produced.
- ser_valid and ser_ready are never high outside SHIFT. There is no backpressure on the serial ports; the serial partner must keep up.

Decomposition:
- Package usr_pkg holds:
  - SEL_HOLD/SEL_DOWN/SEL_UP/SEL_LOAD constants.
  - OP_TX/OP_RX/OP_ROTL/OP_ROTR constants.
  - State enum.
- Natural sub-module: usr_seq_cnt, an AMT_W-bit loadable down-counter with a zero flag.
- The USR itself is instantiated by the integration wrapper, not inside this block.

Test Plan (WIDTH=4, with a behavioural USR model):
- TX cmd_data=4'b1011 → ser_out 1,1,0,1 with ser_valid in cycles 2–5; rsp_valid at cycle 6 with rsp_data=4'b0000.
- RX, ser_in 1,0,0,0 on the ser_ready cycles → rsp_data=4'b1000 at cycle 6.
- ROTL data=4'b1001 amt=1 → rsp_data=4'b0011 at cycle 3. ROTR data=4'b1001 amt=2 → rsp_data=4'b0110 at cycle 4.
- ROTL data=4'b0110 amt=0 → no SHIFT cycle; rsp_valid at cycle 2 with rsp_data=4'b0110.
- rst high at cycle 3 of TX → IDLE next edge, usr_select=00, ser_valid=0, no rsp_valid. A following TX 4'b0001 completes normally.
- rsp_ready low for 5 cycles after rsp_valid, with cmd_valid=1 throughout → rsp_data stable, cmd_ready=0, no new command started. Command is accepted one cycle after the response handshake.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the universal-shift-register sequencer.
//   SEL_*  : usr_select encodings driven to the USR instance
//   OP_*   : command opcodes carried on cmd_op
//   state_t: sequencer FSM states
package usr_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_DOWN = 2'b01;  // q[k] <= q[k+1], q[MSB] <= s_right
    localparam logic [1:0] SEL_UP   = 2'b10;  // q[k] <= q[k-1], q[0]   <= s_left
    localparam logic [1:0] SEL_LOAD = 2'b11;

    localparam logic [1:0] OP_TX   = 2'b00;
    localparam logic [1:0] OP_RX   = 2'b01;
    localparam logic [1:0] OP_ROTL = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

endpackage

// File: rtl/usr_seq_cnt.sv
// Loadable down-counter used to pace SHIFT cycles.
//   clk, rst  : clock, synchronous active-high reset (clears count)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; saturates at zero
//   count     : current count
//   zero      : count == 0
module usr_seq_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/usr_seq.sv
// Command sequencer for a WIDTH-bit universal shift register.
// Accepts TX / RX / ROTL / ROTR commands, walks the external USR through
// LOAD and SHIFT cycles, and returns the final contents on a response channel.
//   cmd_*      : command handshake (op, load data, rotate amount)
//   ser_out/ser_valid : transmitted bit stream, LSB first
//   ser_in/ser_ready  : received bit stream, sampled while ser_ready
//   rsp_*      : response handshake carrying final USR contents
//   busy       : FSM not idle
//   usr_*      : control of / feedback from the external USR instance
module usr_seq
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [AMT_W-1:0] cmd_amt,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_in,
    output logic             ser_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [1:0]       usr_select,
    output logic             usr_s_left,
    output logic             usr_s_right,
    output logic [WIDTH-1:0] usr_i,
    input  logic [WIDTH-1:0] usr_q
);

    // Counter must hold both WIDTH (TX/RX) and the largest rotate amount.
    localparam int WCNT_W = $clog2(WIDTH + 1);
    localparam int CNT_W  = (AMT_W > WCNT_W) ? AMT_W : WCNT_W;

    state_t           state_reg, state_next;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] data_reg;

    logic             cmd_fire;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    assign cmd_fire     = cmd_valid && cmd_ready;
    assign cnt_load_val = ((cmd_op == OP_TX) || (cmd_op == OP_RX))
                          ? CNT_W'(WIDTH) : CNT_W'(cmd_amt);

    usr_seq_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cmd_fire),
        .load_val (cnt_load_val),
        .dec      (state_reg == ST_SHIFT),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_TX;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (cmd_fire) begin
                op_reg   <= cmd_op;
                data_reg <= cmd_data;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (cmd_fire) state_next = ST_LOAD;
            ST_LOAD:  state_next = cnt_zero ? ST_RESP : ST_SHIFT;
            // Count still holds the remaining shifts including this one.
            ST_SHIFT: if (cnt_val == CNT_W'(1)) state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs are forced to their idle values while rst is asserted, since a
    // synchronous reset leaves the state register untouched until the edge.
    always_comb begin
        cmd_ready   = 1'b0;
        ser_out     = 1'b0;
        ser_valid   = 1'b0;
        ser_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        busy        = 1'b0;
        usr_select  = SEL_HOLD;
        usr_s_left  = 1'b0;
        usr_s_right = 1'b0;
        usr_i       = '0;
        if (!rst) begin
            busy = (state_reg != ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    cmd_ready = 1'b1;
                end
                ST_LOAD: begin
                    usr_select = SEL_LOAD;
                    usr_i      = (op_reg == OP_RX) ? '0 : data_reg;
                end
                ST_SHIFT: begin
                    case (op_reg)
                        OP_TX: begin
                            usr_select = SEL_DOWN;
                            ser_out    = usr_q[0];
                            ser_valid  = 1'b1;
                        end
                        OP_RX: begin
                            // After WIDTH up-shifts the first bit sits in the MSB.
                            usr_select = SEL_UP;
                            usr_s_left = ser_in;
                            ser_ready  = 1'b1;
                        end
                        OP_ROTL: begin
                            usr_select = SEL_UP;
                            usr_s_left = usr_q[WIDTH-1];
                        end
                        default: begin
                            usr_select  = SEL_DOWN;
                            usr_s_right = usr_q[0];
                        end
                    endcase
                end
                ST_RESP: begin
                    rsp_valid = 1'b1;
                    rsp_data  = usr_q;
                end
                default: begin
                    busy = 1'b1;
                end
            endcase
        end
    end

endmodule
